// File: rtl/vout_max6675.sv
// MAX6675 responder: SPI slave that serves a 16-bit temperature read frame.
// Define VOUT_MAX6675_CONV_EN to enable the periodic conversion model.
module vout_max6675 #(
  parameter int CONV_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        spi_sclk,
  input  logic        spi_cs,
  output logic        spi_miso,
  output logic        spi_miso_oe,
  input  logic [11:0] temperature,
  input  logic        tc_open,
  output logic        frame_done,
  output logic        busy
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SHIFT = 1'b1;

  logic        r_sclk_s1, r_sclk_s2, r_sclk_s3;
  logic        r_cs_s1, r_cs_s2, r_cs_s3;
  logic [0:0]  r_state;
  logic [15:0] r_shift;
  logic [4:0]  r_bit_cnt;
  logic        r_done;

  logic        w_cs_fall;
  logic        w_cs_rise;
  logic        w_sclk_fall;
  logic [15:0] w_frame;

  assign w_cs_fall   = r_cs_s3 & ~r_cs_s2;
  assign w_cs_rise   = ~r_cs_s3 & r_cs_s2;
  assign w_sclk_fall = r_sclk_s3 & ~r_sclk_s2;

`ifdef VOUT_MAX6675_CONV_EN
  localparam int CW = $clog2(CONV_CYCLES);
  localparam logic [CW-1:0] RELOAD = CW'(CONV_CYCLES - 1);

  logic [CW-1:0] r_conv_cnt;
  logic [12:0]   r_result;

  // Conversions only run while the bus is idle, like the real part.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conv_cnt <= RELOAD;
      r_result   <= '0;
    end else if (w_cs_rise) begin
      r_conv_cnt <= RELOAD;
    end else if (r_cs_s2) begin
      if (r_conv_cnt == '0) begin
        r_conv_cnt <= RELOAD;
        r_result   <= {temperature, tc_open};
      end else begin
        r_conv_cnt <= r_conv_cnt - 1'b1;
      end
    end
  end

  assign w_frame = {1'b0, r_result, 2'b00};
`else
  logic w_unused_conv;
  assign w_unused_conv = CONV_CYCLES[0];
  assign w_frame = {1'b0, temperature, tc_open, 2'b00};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_s1 <= 1'b0;
      r_sclk_s2 <= 1'b0;
      r_sclk_s3 <= 1'b0;
      r_cs_s1   <= 1'b1;
      r_cs_s2   <= 1'b1;
      r_cs_s3   <= 1'b1;
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_done    <= 1'b0;
    end else begin
      r_sclk_s1 <= spi_sclk;
      r_sclk_s2 <= r_sclk_s1;
      r_sclk_s3 <= r_sclk_s2;
      r_cs_s1   <= spi_cs;
      r_cs_s2   <= r_cs_s1;
      r_cs_s3   <= r_cs_s2;
      r_done    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_cs_fall) begin
            r_state   <= S_SHIFT;
            r_shift   <= w_frame;
            r_bit_cnt <= '0;
          end
        end
        S_SHIFT: begin
          // CS rise has priority over a coincident SCLK fall.
          if (w_cs_rise) begin
            r_state <= S_IDLE;
            r_shift <= '0;
            r_done  <= (r_bit_cnt == 5'd16);
          end else if (w_sclk_fall && r_bit_cnt != 5'd16) begin
            r_shift   <= {r_shift[14:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 5'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign spi_miso    = r_shift[15];
  assign spi_miso_oe = r_state;
  assign busy        = r_state;
  assign frame_done  = r_done;

endmodule

// File: tb/tb_vout_max6675.sv
// Self-checking bench for vout_max6675: SPI master plus frame model.
// Build with VOUT_MAX6675_CONV_EN to exercise the conversion model.
module tb_vout_max6675;

  logic        clk;
  logic        rst_n;
  logic        spi_sclk;
  logic        spi_cs;
  logic        spi_miso;
  logic        spi_miso_oe;
  logic [11:0] temperature;
  logic        tc_open;
  logic        frame_done;
  logic        busy;

  int vectors;
  int errors;
  int done_seen;
  int exp_done;
  int cs_stable;
  logic prev_cs;
  logic prev_done;

  vout_max6675 #(.CONV_CYCLES(100)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .spi_sclk(spi_sclk),
    .spi_cs(spi_cs),
    .spi_miso(spi_miso),
    .spi_miso_oe(spi_miso_oe),
    .temperature(temperature),
    .tc_open(tc_open),
    .frame_done(frame_done),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mframe(input logic [11:0] t,
                                         input logic o);
    return (16'(t) << 3) | (16'(o) << 2);
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle checks of the handshake-level outputs.
  initial begin
    cs_stable = 0;
    prev_cs   = 1'b1;
    prev_done = 1'b0;
    done_seen = 0;
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) begin
      cs_stable = 0;
      chk("reset oe", spi_miso_oe, 0);
      chk("reset miso", spi_miso, 0);
      chk("reset busy", busy, 0);
      chk("reset done", frame_done, 0);
    end else begin
      if (spi_cs !== prev_cs) cs_stable = 0;
      else cs_stable++;
      if (cs_stable >= 3) begin
        chk("oe vs cs", spi_miso_oe, !spi_cs);
        chk("busy vs cs", busy, !spi_cs);
        if (spi_cs) chk("idle miso", spi_miso, 0);
      end
      if (frame_done) begin
        done_seen++;
        chk("done width", prev_done, 0);
      end
    end
    prev_cs   = spi_cs;
    prev_done = frame_done;
  end

  task automatic read_frame(input int nfall, input int chg_at,
                            input logic [11:0] chg_val, input int rst_at,
                            input logic [15:0] exp, output logic [15:0] got);
    logic b;
    logic e;
    got = '0;
    spi_cs = 1'b0;
    wait_clk(6);
    for (int i = 0; i < nfall; i++) begin
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst miso now", spi_miso, 0);
        chk("rst oe now", spi_miso_oe, 0);
        spi_cs   = 1'b1;
        spi_sclk = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(5);
        return;
      end
      if (i == chg_at) temperature = chg_val;
      b = spi_miso;
      e = (i < 16) ? exp[4'(15 - i)] : 1'b0;
      chk($sformatf("miso bit %0d", i), b, e);
      if (i < 16) got[4'(15 - i)] = b;
      spi_sclk = 1'b1;
      wait_clk(6);
      spi_sclk = 1'b0;
      wait_clk(6);
    end
    spi_cs = 1'b1;
    wait_clk(8);
    if (nfall >= 16) exp_done++;
    chk("frame_done count", done_seen, exp_done);
  endtask

  logic [15:0] got;
  logic [15:0] exp;

  initial begin
    vectors     = 0;
    errors      = 0;
    exp_done    = 0;
    rst_n       = 1'b0;
    spi_cs      = 1'b1;
    spi_sclk    = 1'b0;
    temperature = '0;
    tc_open     = 1'b0;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(4);

`ifndef VOUT_MAX6675_CONV_EN
    temperature = 12'h190;
    tc_open = 1'b0;
    read_frame(16, -1, 12'h0, -1, mframe(temperature, tc_open), got);
    chk("live word", got, 16'h0C80);

    temperature = 12'hFFF;
    tc_open = 1'b1;
    read_frame(18, -1, 12'h0, -1, mframe(temperature, tc_open), got);
    chk("open word", got, 16'h7FFC);

    temperature = 12'h0AB;
    tc_open = 1'b0;
    read_frame(7, -1, 12'h0, -1, mframe(temperature, tc_open), got);
    read_frame(16, -1, 12'h0, -1, mframe(temperature, tc_open), got);
    chk("after abort", got, 16'h0558);

    temperature = 12'h010;
    read_frame(16, 5, 12'h020, -1, 16'h0080, got);
    chk("mid-frame word", got, 16'h0080);

    temperature = 12'h123;
    read_frame(16, -1, 12'h0, 8, mframe(temperature, tc_open), got);
    temperature = 12'h2A5;
    tc_open = 1'b1;
    read_frame(16, -1, 12'h0, -1, mframe(temperature, tc_open), got);
    chk("after reset", got, 16'h152C);

    for (int k = 0; k < 25; k++) begin
      temperature = 12'($urandom);
      tc_open = 1'($urandom);
      exp = mframe(temperature, tc_open);
      read_frame(int'($urandom_range(1, 18)), -1, 12'h0, -1, exp, got);
    end
`else
    temperature = 12'h064;
    tc_open = 1'b0;
    wait_clk(43);
    read_frame(16, -1, 12'h0, -1, 16'h0000, got);
    chk("pre-conv word", got, 16'h0000);
    wait_clk(150);
    read_frame(16, -1, 12'h0, -1, 16'h0320, got);
    chk("conv word", got, 16'h0320);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
